iq_fifo: RTL and testbench

- Instruction queue between decode/rename and the issue stage.
- Accepts up to 4 renamed entries per cycle, in order, from decode.
- Presents the oldest 4 entries to the issue stage as a combinational window and retires 0–4 of them per cycle on the issue stage's consume handshake.
- Flushed wholesale on a taken or mispredicted branch.

---
 rtl/iq_fifo.sv | 149 ++++++++++++++
 tb/tb_iq_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/iq_fifo.sv
// Instruction queue between decode/rename and issue: 4-wide in-order enqueue,
// a 4-entry oldest-first window for issue, and wholesale flush on redirect.

package iq_pkg;
    localparam int ROB_DEPTHLOG = 4;

    typedef struct packed {
        logic [31:0]             pc;
        logic [31:0]             insn;
        logic [5:0]              dst_preg;
        logic [ROB_DEPTHLOG-1:0] rob_slot;
    } iq_entry_t;
endpackage

module iq_fifo #(
    parameter int DEPTHLOG     = 4,
    parameter int ROB_DEPTHLOG = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [2:0]           in_count,
    input  iq_pkg::iq_entry_t    in_insns [4],
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 ext_enable,
    input  logic [1:0]           ext_consumed,
    output logic [3:0]           ext_valid,
    output iq_pkg::iq_entry_t    insns [4],
    output logic                 empty,
    output logic [DEPTHLOG:0]    count,
    output logic                 proto_err
);
    localparam int DEPTH = 1 << DEPTHLOG;
    localparam logic [DEPTHLOG:0] DEPTH_C = (DEPTHLOG + 1)'(DEPTH);
    localparam logic [DEPTHLOG:0] GROUP_C = (DEPTHLOG + 1)'(4);

    // The entry layout lives in iq_pkg, so the rob slot width must agree with it.
    if ((ROB_DEPTHLOG != iq_pkg::ROB_DEPTHLOG) || (DEPTHLOG < 3)) begin : g_bad_config
        $error("iq_fifo: unsupported DEPTHLOG/ROB_DEPTHLOG combination");
    end

    iq_pkg::iq_entry_t    mem_q [DEPTH];
    logic [DEPTHLOG-1:0]  head_q, head_d;
    logic [DEPTHLOG-1:0]  tail_q, tail_d;
    logic [DEPTHLOG:0]    count_q, count_d;
    logic                 proto_err_q, proto_err_d;

    logic [2:0]           in_n_s;
    logic [2:0]           enq_n_s;
    logic [2:0]           deq_req_s;
    logic [2:0]           deq_n_s;
    logic                 over_consume_s;
    logic                 enq_blocked_s;
    logic [DEPTHLOG:0]    free_s;
    logic                 in_ready_s;
    logic [3:0]           wr_en_s;
    logic [DEPTHLOG-1:0]  wr_idx_s [4];

    // Accept/retire amounts, error detection and next-state pointers.
    always_comb begin
        in_n_s         = (in_count > 3'd4) ? 3'd4 : in_count;
        free_s         = DEPTH_C - count_q;
        in_ready_s     = (free_s >= GROUP_C);
        deq_req_s      = {1'b0, ext_consumed} + 3'd1;
        over_consume_s = ext_enable && ((DEPTHLOG + 1)'(deq_req_s) > count_q);
        enq_blocked_s  = (in_n_s != 3'd0) && !in_ready_s;

        if (flush) begin
            enq_n_s = 3'd0;
        end else if (in_ready_s) begin
            enq_n_s = in_n_s;
        end else begin
            enq_n_s = 3'd0;
        end

        // An over-consume can only happen while count < 4, so its low bits are exact.
        if (flush || !ext_enable) begin
            deq_n_s = 3'd0;
        end else if (over_consume_s) begin
            deq_n_s = count_q[2:0];
        end else begin
            deq_n_s = deq_req_s;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + DEPTHLOG'(deq_n_s);
            tail_d  = tail_q + DEPTHLOG'(enq_n_s);
            count_d = count_q + (DEPTHLOG + 1)'(enq_n_s) - (DEPTHLOG + 1)'(deq_n_s);
        end

        if (flush) begin
            proto_err_d = proto_err_q;
        end else begin
            proto_err_d = proto_err_q | over_consume_s | enq_blocked_s;
        end

        for (int i = 0; i < 4; i++) begin
            wr_en_s[i]  = (3'(i) < enq_n_s);
            wr_idx_s[i] = tail_q + DEPTHLOG'(i);
        end
    end

    // Pointer, occupancy and sticky error state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Entry storage; flush leaves contents in place since count gates visibility.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en_s[i]) begin
                    mem_q[wr_idx_s[i]] <= in_insns[i];
                end
            end
        end
    end

    // Issue window straight off the registers; no enqueue bypass.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ext_valid[i] = (count_q > (DEPTHLOG + 1)'(i));
            insns[i]     = mem_q[head_q + DEPTHLOG'(i)];
        end
        in_ready  = in_ready_s;
        empty     = (count_q == '0);
        count     = count_q;
        proto_err = proto_err_q;
    end

endmodule

// File: tb/tb_iq_fifo.sv
// Directed table-driven bench for iq_fifo: each row drives one cycle and checks
// the registered-state outputs seen during that cycle.

module tb_iq_fifo;
    logic              clock;
    logic              reset_n;
    logic [2:0]        in_count;
    iq_pkg::iq_entry_t in_insns [4];
    logic              in_ready;
    logic              flush;
    logic              ext_enable;
    logic [1:0]        ext_consumed;
    logic [3:0]        ext_valid;
    iq_pkg::iq_entry_t insns [4];
    logic              empty;
    logic [4:0]        count;
    logic              proto_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]  inc;
        logic [31:0] pcb;
        logic        fl;
        logic        en;
        logic [1:0]  cons;
        logic [4:0]  ecnt;
        logic        erdy;
        logic [3:0]  evld;
        logic [31:0] epc;
        logic        eprot;
    } vec_t;

    vec_t tbl [23];
    vec_t tbl2 [6];

    iq_fifo #(.DEPTHLOG(4), .ROB_DEPTHLOG(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_count     (in_count),
        .in_insns     (in_insns),
        .in_ready     (in_ready),
        .flush        (flush),
        .ext_enable   (ext_enable),
        .ext_consumed (ext_consumed),
        .ext_valid    (ext_valid),
        .insns        (insns),
        .empty        (empty),
        .count        (count),
        .proto_err    (proto_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic iq_pkg::iq_entry_t mk(input logic [31:0] pc);
        iq_pkg::iq_entry_t e;
        e.pc       = pc;
        e.insn     = ~pc;
        e.dst_preg = pc[7:2];
        e.rob_slot = pc[5:2];
        return e;
    endfunction

    task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int row);
        logic win_ok;
        in_count     = v.inc;
        flush        = v.fl;
        ext_enable   = v.en;
        ext_consumed = v.cons;
        for (int i = 0; i < 4; i++) in_insns[i] = mk(v.pcb + 32'(4 * i));
        #1;
        check("count", row, 64'(count), 64'(v.ecnt));
        check("in_ready", row, 64'(in_ready), 64'(v.erdy));
        check("ext_valid", row, 64'(ext_valid), 64'(v.evld));
        check("empty", row, 64'(empty), 64'(v.ecnt == 5'd0));
        check("proto_err", row, 64'(proto_err), 64'(v.eprot));
        win_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v.evld[i] && (insns[i] !== mk(v.epc + 32'(4 * i)))) win_ok = 1'b0;
        end
        check("window", row, 64'(insns[0].pc), (win_ok ? 64'(insns[0].pc) : 64'(v.epc)) | 64'(!win_ok) << 32);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        in_count     = 3'd0;
        flush        = 1'b0;
        ext_enable   = 1'b0;
        ext_consumed = 2'd0;
        for (int i = 0; i < 4; i++) in_insns[i] = '0;

        //             inc   pcb          fl    en    cons   ecnt   erdy  evld     epc          eprot
        tbl[0]  = '{3'd0, 32'h0,      1'b0, 1'b0, 2'd0, 5'd0,  1'b1, 4'b0000, 32'h0,      1'b0};
        tbl[1]  = '{3'd4, 32'h100,    1'b0, 1'b0, 2'd0, 5'd0,  1'b1, 4'b0000, 32'h0,      1'b0};
        tbl[2]  = '{3'd0, 32'h0,      1'b0, 1'b1, 2'd1, 5'd4,  1'b1, 4'b1111, 32'h100,    1'b0};
        tbl[3]  = '{3'd0, 32'h0,      1'b0, 1'b1, 2'd1, 5'd2,  1'b1, 4'b0011, 32'h108,    1'b0};
        tbl[4]  = '{3'd4, 32'h200,    1'b0, 1'b0, 2'd0, 5'd0,  1'b1, 4'b0000, 32'h0,      1'b0};
        tbl[5]  = '{3'd4, 32'h210,    1'b0, 1'b0, 2'd0, 5'd4,  1'b1, 4'b1111, 32'h200,    1'b0};
        tbl[6]  = '{3'd4, 32'h220,    1'b0, 1'b0, 2'd0, 5'd8,  1'b1, 4'b1111, 32'h200,    1'b0};
        tbl[7]  = '{3'd1, 32'h230,    1'b0, 1'b0, 2'd0, 5'd12, 1'b1, 4'b1111, 32'h200,    1'b0};
        tbl[8]  = '{3'd0, 32'h0,      1'b0, 1'b0, 2'd0, 5'd13, 1'b0, 4'b1111, 32'h200,    1'b0};
        tbl[9]  = '{3'd0, 32'h0,      1'b0, 1'b1, 2'd0, 5'd13, 1'b0, 4'b1111, 32'h200,    1'b0};
        tbl[10] = '{3'd3, 32'h234,    1'b0, 1'b0, 2'd0, 5'd12, 1'b1, 4'b1111, 32'h204,    1'b0};
        tbl[11] = '{3'd0, 32'h0,      1'b0, 1'b1, 2'd3, 5'd15, 1'b0, 4'b1111, 32'h204,    1'b0};
        tbl[12] = '{3'd0, 32'h0,      1'b0, 1'b1, 2'd3, 5'd11, 1'b1, 4'b1111, 32'h214,    1'b0};
        tbl[13] = '{3'd0, 32'h0,      1'b0, 1'b1, 2'd1, 5'd7,  1'b1, 4'b1111, 32'h224,    1'b0};
        tbl[14] = '{3'd4, 32'h240,    1'b0, 1'b1, 2'd1, 5'd5,  1'b1, 4'b1111, 32'h22C,    1'b0};
        tbl[15] = '{3'd0, 32'h0,      1'b0, 1'b0, 2'd0, 5'd7,  1'b1, 4'b1111, 32'h234,    1'b0};
        tbl[16] = '{3'd4, 32'h500,    1'b1, 1'b1, 2'd3, 5'd7,  1'b1, 4'b1111, 32'h234,    1'b0};
        tbl[17] = '{3'd0, 32'h0,      1'b0, 1'b0, 2'd0, 5'd0,  1'b1, 4'b0000, 32'h0,      1'b0};
        tbl[18] = '{3'd2, 32'h600,    1'b0, 1'b0, 2'd0, 5'd0,  1'b1, 4'b0000, 32'h0,      1'b0};
        tbl[19] = '{3'd0, 32'h0,      1'b0, 1'b1, 2'd3, 5'd2,  1'b1, 4'b0011, 32'h600,    1'b0};
        tbl[20] = '{3'd0, 32'h0,      1'b1, 1'b0, 2'd0, 5'd0,  1'b1, 4'b0000, 32'h0,      1'b1};
        tbl[21] = '{3'd0, 32'h0,      1'b0, 1'b0, 2'd0, 5'd0,  1'b1, 4'b0000, 32'h0,      1'b1};
        tbl[22] = '{3'd0, 32'h0,      1'b0, 1'b0, 2'd0, 5'd0,  1'b1, 4'b0000, 32'h0,      1'b1};

        // After a mid-run reset: clamp of in_count=7, fill to depth, blocked group.
        tbl2[0] = '{3'd7, 32'h700,    1'b0, 1'b0, 2'd0, 5'd0,  1'b1, 4'b0000, 32'h0,      1'b0};
        tbl2[1] = '{3'd4, 32'h710,    1'b0, 1'b0, 2'd0, 5'd4,  1'b1, 4'b1111, 32'h700,    1'b0};
        tbl2[2] = '{3'd4, 32'h720,    1'b0, 1'b0, 2'd0, 5'd8,  1'b1, 4'b1111, 32'h700,    1'b0};
        tbl2[3] = '{3'd4, 32'h730,    1'b0, 1'b0, 2'd0, 5'd12, 1'b1, 4'b1111, 32'h700,    1'b0};
        tbl2[4] = '{3'd4, 32'h900,    1'b0, 1'b0, 2'd0, 5'd16, 1'b0, 4'b1111, 32'h700,    1'b0};
        tbl2[5] = '{3'd0, 32'h0,      1'b0, 1'b1, 2'd3, 5'd16, 1'b0, 4'b1111, 32'h700,    1'b1};

        #12;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int r = 0; r < 23; r++) run_vec(tbl[r], r);

        // Asynchronous reset mid-cycle clears the sticky error immediately.
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_proto_err", 100, 64'(proto_err), 64'(1'b0));
        check("reset_empty", 100, 64'(empty), 64'(1'b1));
        check("reset_window0", 100, 64'(insns[0].pc), 64'(32'h0));
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int r = 0; r < 6; r++) run_vec(tbl2[r], 200 + r);

        in_count   = 3'd0;
        ext_enable = 1'b0;
        #1;
        check("post_drain_count", 300, 64'(count), 64'(5'd12));
        check("post_drain_ready", 300, 64'(in_ready), 64'(1'b1));
        check("post_drain_head", 300, 64'(insns[0].pc), 64'(32'h710));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
